vga_fb_arbiter: RTL

- Shares one single-port video SRAM between the VGA scan-out fetch path (hard real-time, fixed priority) and a CPU-side read/write port (req/ack handshake).
- Sits between vga_driver's pixel fetch logic, the CPU bus bridge and the external SRAM pins.
- Sequences every SRAM access: address, output enable, write enable and the read-data capture.

---
 rtl/vga_fb_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port video SRAM between the VGA fetch
// path (fixed priority, one-deep pending slot) and a CPU req/ack port.
module vga_fb_arbiter #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 1
) (
    input  logic              i_clk50M,
    input  logic              i_rst_n,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic [DATA_W-1:0] o_vga_data,
    output logic              o_vga_valid,
    output logic              o_vga_ovf,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_oe_n,
    output logic              o_mem_we_n
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VGA_ACC = 2'd1,
        CPU_RD  = 2'd2,
        CPU_WR  = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(ACC_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_vga_pend;
    logic [ADDR_W-1:0] r_vga_addr;
    logic              r_vga_ovf;
    logic              r_vga_valid;
    logic [DATA_W-1:0] r_vga_data;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_oe_n;
    logic              r_mem_we_n;

    logic              w_last;
    logic              w_decide;
    logic              w_vga_any;
    logic              w_cpu_last;
    logic              w_cpu_ok;
    logic              w_grant_vga;
    logic              w_grant_cpu;
    logic              w_go_idle;
    logic [ADDR_W-1:0] w_vga_gaddr;
    logic              w_oe_n_nxt;
    logic              w_we_n_nxt;

    assign w_last      = (r_state != IDLE) && (r_cnt == LAST);
    assign w_decide    = (r_state == IDLE) || w_last;
    assign w_vga_any   = r_vga_pend | i_vga_req;
    assign w_cpu_last  = w_last && ((r_state == CPU_RD) || (r_state == CPU_WR));
    // The request being finished or acknowledged must not be granted again.
    assign w_cpu_ok    = i_cpu_req && !r_cpu_ack && !w_cpu_last;
    assign w_grant_vga = w_decide && w_vga_any;
    assign w_grant_cpu = w_decide && !w_vga_any && w_cpu_ok;
    assign w_go_idle   = w_decide && !w_vga_any && !w_cpu_ok;
    assign w_vga_gaddr = r_vga_pend ? r_vga_addr : i_vga_addr;

    always_ff @(posedge i_clk50M) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_decide ? 4'd0 : r_cnt + 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            w_grant_vga: w_state_nxt = VGA_ACC;
            w_grant_cpu: w_state_nxt = i_cpu_we ? CPU_WR : CPU_RD;
            w_go_idle:   w_state_nxt = IDLE;
            default:     w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        w_oe_n_nxt = 1'b1;
        w_we_n_nxt = 1'b1;
        unique case (w_state_nxt)
            VGA_ACC: w_oe_n_nxt = 1'b0;
            CPU_RD:  w_oe_n_nxt = 1'b0;
            CPU_WR:  w_we_n_nxt = 1'b0;
            default: w_oe_n_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk50M) begin
        if (!i_rst_n) begin
            r_vga_pend  <= 1'b0;
            r_vga_addr  <= '0;
            r_vga_ovf   <= 1'b0;
        end else if (w_grant_vga) begin
            // Pending slot is consumed; a fresh pulse on this edge refills it.
            r_vga_pend <= r_vga_pend & i_vga_req;
            if (r_vga_pend && i_vga_req) begin
                r_vga_addr <= i_vga_addr;
            end
        end else if (i_vga_req && !r_vga_pend) begin
            r_vga_pend <= 1'b1;
            r_vga_addr <= i_vga_addr;
        end else if (i_vga_req) begin
            r_vga_ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_clk50M) begin
        if (!i_rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_oe_n  <= 1'b1;
            r_mem_we_n  <= 1'b1;
        end else begin
            r_mem_oe_n <= w_oe_n_nxt;
            r_mem_we_n <= w_we_n_nxt;
            if (w_grant_vga) begin
                r_mem_addr <= w_vga_gaddr;
            end else if (w_grant_cpu) begin
                r_mem_addr <= i_cpu_addr;
                if (i_cpu_we) begin
                    r_mem_wdata <= i_cpu_wdata;
                end
            end
        end
    end

    always_ff @(posedge i_clk50M) begin
        if (!i_rst_n) begin
            r_vga_data  <= '0;
            r_cpu_rdata <= '0;
            r_vga_valid <= 1'b0;
            r_cpu_ack   <= 1'b0;
        end else begin
            r_vga_valid <= w_last && (r_state == VGA_ACC);
            r_cpu_ack   <= w_cpu_last;
            if (w_last && (r_state == VGA_ACC)) begin
                r_vga_data <= i_mem_rdata;
            end
            if (w_last && (r_state == CPU_RD)) begin
                r_cpu_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_vga_data  = r_vga_data;
    assign o_vga_valid = r_vga_valid;
    assign o_vga_ovf   = r_vga_ovf;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_oe_n  = r_mem_oe_n;
    assign o_mem_we_n  = r_mem_we_n;

endmodule
